gpr_wb_arbiter: RTL

Writer-side front end of the 32-entry, 3-read/1-write GPR file. It merges two writeback sources, the EX result bus and LSU load returns, onto the file's single write port. EX always has priority. LSU writes that lose arbitration are held in a small in-order buffer, with valid/ready backpressure. The block also flags read-after-write hazards against buffered writes, so decode can stall before it captures a read address.

---
 rtl/gpr_wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the GPR file: EX has priority, losing LSU writes wait in
// an in-order buffer that squashes stale loads and flags read hazards to decode.
package gpr_wb_arbiter_pkg;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_wb_valid,
  input  logic [AW-1:0] ex_wb_addr,
  input  logic [DW-1:0] ex_wb_data,
  input  logic          lsu_wb_valid,
  output logic          lsu_wb_ready,
  input  logic [AW-1:0] lsu_wb_addr,
  input  logic [DW-1:0] lsu_wb_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] chk_addr_a,
  input  logic [AW-1:0] chk_addr_b,
  input  logic [AW-1:0] chk_addr_c,
  output logic          hzd_a,
  output logic          hzd_b,
  output logic          hzd_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        ent_d [DEPTH];
  logic             wr_en_q, wr_en_d;
  wb_entry_t        wr_q, wr_d;

  logic lsu_acc, buf_empty, pop, byp, push;

  assign lsu_wb_ready = (count_q != CNT_W'(DEPTH));
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_q.addr;
  assign wr_data      = wr_q.data;

  // Arbitration, buffer update and EX-driven squash of older same-address loads
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    live_d  = live_q;
    ent_d   = ent_q;
    wr_en_d = 1'b0;
    wr_d    = wr_q;

    lsu_acc   = lsu_wb_valid & lsu_wb_ready;
    buf_empty = (count_q == CNT_W'(0));
    pop       = !ex_wb_valid && !buf_empty;
    byp       = !ex_wb_valid && buf_empty && lsu_acc;
    push      = lsu_acc && !byp;

    if (ex_wb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].addr == ex_wb_addr) live_d[i] = 1'b0;
      end
    end

    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end

    if (push) begin
      ent_d[tail_q]  = '{addr: lsu_wb_addr, data: lsu_wb_data};
      live_d[tail_q] = !(ex_wb_valid && (lsu_wb_addr == ex_wb_addr));
      tail_d         = tail_q + PTR_W'(1);
    end

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (ex_wb_valid) begin
      wr_en_d = 1'b1;
      wr_d    = '{addr: ex_wb_addr, data: ex_wb_data};
    end else if (pop) begin
      // A squashed head drains as a bubble and leaves the address/data alone
      wr_en_d = live_q[head_q];
      if (live_q[head_q]) wr_d = ent_q[head_q];
    end else if (byp) begin
      wr_en_d = 1'b1;
      wr_d    = '{addr: lsu_wb_addr, data: lsu_wb_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
      ent_q   <= ent_d;
    end
  end

  // Hazards look only at registered buffer state
  always_comb begin
    hzd_a = 1'b0;
    hzd_b = 1'b0;
    hzd_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hzd_a = hzd_a | (live_q[i] && (ent_q[i].addr == chk_addr_a));
      hzd_b = hzd_b | (live_q[i] && (ent_q[i].addr == chk_addr_b));
      hzd_c = hzd_c | (live_q[i] && (ent_q[i].addr == chk_addr_c));
    end
  end

endmodule
